// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock behind a start/ready
// handshake, with a short path for a zero divisor.
module seq_divider #(
   parameter int WIDTH = 4
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             start,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             ready,
   output logic             busy,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Handshake: start is level-sampled only in IDLE; ready is a one-cycle
   // pulse in DONE marking quotient/remainder/div_by_zero as freshly valid.
   logic [1:0]       state;
   logic [WIDTH:0]   r;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] d;
   logic [CW-1:0]    cnt;

   logic [WIDTH:0]   t;
   logic             take;
   logic [WIDTH:0]   r_step;
   logic [WIDTH-1:0] q_step;

   always_comb begin
      t      = {r[WIDTH-1:0], q[WIDTH-1]};
      take   = (t >= {1'b0, d});
      r_step = take ? (t - {1'b0, d}) : t;
      q_step = {q[WIDTH-2:0], take};
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state       <= IDLE;
         r           <= '0;
         q           <= '0;
         d           <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         ready       <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         ready <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  r   <= '0;
                  q   <= dividend;
                  d   <= divisor;
                  cnt <= CW'(WIDTH);
                  // A zero divisor skips RUN and reports straight away.
                  if (divisor == '0) begin
                     state       <= DONE;
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     ready       <= 1'b1;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               r   <= r_step;
               q   <= q_step;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state       <= DONE;
                  quotient    <= q_step;
                  remainder   <= r_step[WIDTH-1:0];
                  div_by_zero <= 1'b0;
                  ready       <= 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider (WIDTH=4): directed cases, random operands and an
// exhaustive back-to-back sweep against plain '/' and '%' arithmetic.
module tb_seq_divider;

   localparam int W = 4;

   logic         clk_in = 1'b0;
   logic         rst_in = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         ready;
   logic         busy;
   logic         div_by_zero;

   int n_checks = 0;
   int n_fail = 0;

   seq_divider #(.WIDTH(W)) dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .dividend    (dividend),
      .divisor     (divisor),
      .start       (start),
      .quotient    (quotient),
      .remainder   (remainder),
      .ready       (ready),
      .busy        (busy),
      .div_by_zero (div_by_zero)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Issues one operation from IDLE and checks latency, result and hold.
   task automatic run_op(input string tag, input int a, input int b);
      int k;
      int eq;
      int er;
      int ez;
      logic [W-1:0] held_q;
      eq = (b == 0) ? (1 << W) - 1 : a / b;
      er = (b == 0) ? a : a % b;
      ez = (b == 0) ? 1 : 0;
      @(negedge clk_in);
      dividend = W'(a);
      divisor  = W'(b);
      start    = 1'b1;
      @(negedge clk_in);
      start    = 1'b0;
      dividend = W'($urandom_range(0, (1 << W) - 1));
      divisor  = W'($urandom_range(0, (1 << W) - 1));
      chk({tag, ".busy"}, 32'(busy), 1);
      k = 0;
      while (!ready && k < 20) begin
         @(negedge clk_in);
         k++;
      end
      chk({tag, ".latency"}, k, (b == 0) ? 0 : W);
      chk({tag, ".quotient"}, 32'(quotient), eq);
      chk({tag, ".remainder"}, 32'(remainder), er);
      chk({tag, ".dbz"}, 32'(div_by_zero), ez);
      held_q = quotient;
      @(negedge clk_in);
      chk({tag, ".ready_low"}, 32'(ready), 0);
      chk({tag, ".busy_low"}, 32'(busy), 0);
      @(negedge clk_in);
      chk({tag, ".hold"}, 32'(quotient), 32'(held_q));
   endtask

   initial begin
      int pulses;
      int k;
      int a;
      int b;
      int gap;
      logic [W-1:0] cap_q;
      logic [W-1:0] cap_r;

      // Reset values while rst_in is held low
      #12;
      chk("reset.quotient", 32'(quotient), 0);
      chk("reset.remainder", 32'(remainder), 0);
      chk("reset.ready", 32'(ready), 0);
      chk("reset.busy", 32'(busy), 0);
      chk("reset.dbz", 32'(div_by_zero), 0);
      @(negedge clk_in);
      rst_in = 1'b1;

      run_op("d13_4", 13, 4);
      run_op("d15_1", 15, 1);
      run_op("d3_7", 3, 7);
      run_op("d15_15", 15, 15);
      run_op("d0_5", 0, 5);
      run_op("d9_0", 9, 0);
      run_op("d8_3", 8, 3);

      for (int i = 0; i < 20; i++) begin
         a = $urandom_range(0, (1 << W) - 1);
         b = $urandom_range(0, (1 << W) - 1);
         run_op("rand", a, b);
      end

      // New request pulsed during RUN must be dropped
      @(negedge clk_in);
      dividend = 4'd14;
      divisor  = 4'd3;
      start    = 1'b1;
      @(negedge clk_in);
      start = 1'b0;
      @(negedge clk_in);
      dividend = 4'd5;
      divisor  = 4'd1;
      start    = 1'b1;
      @(negedge clk_in);
      start  = 1'b0;
      pulses = 0;
      cap_q  = '0;
      cap_r  = '0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk_in);
         if (ready) begin
            pulses++;
            cap_q = quotient;
            cap_r = remainder;
         end
      end
      chk("ignore_start.pulses", pulses, 1);
      chk("ignore_start.quotient", 32'(cap_q), 4);
      chk("ignore_start.remainder", 32'(cap_r), 2);

      // Asynchronous reset mid-RUN
      @(negedge clk_in);
      dividend = 4'd11;
      divisor  = 4'd2;
      start    = 1'b1;
      @(negedge clk_in);
      start = 1'b0;
      @(negedge clk_in);
      @(negedge clk_in);
      #2;
      rst_in = 1'b0;
      #1;
      chk("abort.quotient", 32'(quotient), 0);
      chk("abort.remainder", 32'(remainder), 0);
      chk("abort.busy", 32'(busy), 0);
      chk("abort.ready", 32'(ready), 0);
      chk("abort.dbz", 32'(div_by_zero), 0);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_in);
         if (ready) pulses++;
      end
      chk("abort.no_ready", pulses, 0);
      rst_in = 1'b1;
      run_op("after_abort", 11, 2);

      // Exhaustive sweep with start held high
      @(negedge clk_in);
      for (int i = 0; i < (1 << (2 * W)); i++) begin
         a = i >> W;
         b = i & ((1 << W) - 1);
         dividend = W'(a);
         divisor  = W'(b);
         start    = 1'b1;
         k = 0;
         do begin
            @(negedge clk_in);
            k++;
         end while (!ready && k < 20);
         // Zero divisor enters DONE on its accepting edge; others spend W edges in RUN.
         if (i == 0) gap = (b == 0) ? 1 : W + 1;
         else        gap = (b == 0) ? 2 : W + 2;
         chk("sweep.gap", k, gap);
         if (b == 0) begin
            chk("sweep.q_dbz", 32'(quotient), (1 << W) - 1);
            chk("sweep.r_dbz", 32'(remainder), a);
            chk("sweep.dbz", 32'(div_by_zero), 1);
         end else begin
            chk("sweep.invariant",
                32'((int'(quotient) * b + int'(remainder) == a) && (int'(remainder) < b)), 1);
            chk("sweep.quotient", 32'(quotient), a / b);
            chk("sweep.remainder", 32'(remainder), a % b);
            chk("sweep.dbz", 32'(div_by_zero), 0);
         end
      end
      start = 1'b0;
      repeat (8) @(negedge clk_in);
      chk("sweep.idle", 32'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
